// File: rtl/riscv_writeback.sv
// rtl/riscv_writeback.sv - register-file write-back sequencer for the non-pipelined RISC-V core
//
// Purpose: accepts one retiring instruction per handshake, selects the result
// source (ALU, load data, PC+4, immediate), waits for and extracts load data,
// then issues a single-cycle register-file write with a done/error pulse.
//
// Ports:
//   i_clk, i_reset       clock; synchronous active-low reset
//   i_wb_valid/o_wb_ready retiring-instruction handshake (ready only in IDLE)
//   i_wb_sel             result source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM
//   i_wb_rd, i_wb_rd_en  destination register and its write enable
//   i_alu_result         ALU result, or load byte address (bits [1:0] = lane)
//   i_pc, i_imm          instruction PC and decoded immediate
//   i_ld_funct3          load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   i_mem_rvalid/rdata   data-memory response (aligned word)
//   o_rf_wen/addr_d/data_d register-file write port, valid for one cycle
//   o_wb_done, o_wb_err  one-cycle completion / error pulse
module riscv_writeback #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_wb_valid,
   output logic                  o_wb_ready,
   input  logic [1:0]            i_wb_sel,
   input  logic [ADDR_WIDTH-1:0] i_wb_rd,
   input  logic                  i_wb_rd_en,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   input  logic [DATA_WIDTH-1:0] i_pc,
   input  logic [DATA_WIDTH-1:0] i_imm,
   input  logic [2:0]            i_ld_funct3,
   input  logic                  i_mem_rvalid,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_rf_wen,
   output logic [ADDR_WIDTH-1:0] o_rf_addr_d,
   output logic [DATA_WIDTH-1:0] o_rf_data_d,
   output logic                  o_wb_done,
   output logic                  o_wb_err
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_MEM = 2'd1,
      S_RESP     = 2'd2
   } state_t;

   // The counter holds the number of idle WAIT_MEM edges already seen, so the
   // edge that would make it reach MEM_TIMEOUT is the one where it equals this.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t                r_state;
   logic [7:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic                  r_rd_en;
   logic [2:0]            r_funct3;
   logic [1:0]            r_off;

   logic                  r_wb_ready;
   logic                  r_rf_wen;
   logic [ADDR_WIDTH-1:0] r_rf_addr;
   logic [DATA_WIDTH-1:0] r_rf_data;
   logic                  r_wb_done;
   logic                  r_wb_err;

   state_t                w_state_nxt;
   logic                  w_accept;
   logic                  w_is_load;
   logic                  w_ld_fault;
   logic [DATA_WIDTH-1:0] w_op_result;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_WIDTH-1:0] w_ld_data;

   logic                  w_ready_nxt;
   logic                  w_wen_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [DATA_WIDTH-1:0] w_data_nxt;
   logic                  w_done_nxt;
   logic                  w_err_nxt;
   logic                  w_en_sel;

   assign w_accept  = i_wb_valid && r_wb_ready;
   assign w_is_load = (i_wb_sel == 2'b01);

   // Faulting loads are detected at accept so they never wait for memory.
   always_comb begin
      w_ld_fault = 1'b0;
      case (i_ld_funct3)
         3'b000, 3'b100: w_ld_fault = 1'b0;
         3'b001, 3'b101: w_ld_fault = i_alu_result[0];
         3'b010:         w_ld_fault = |i_alu_result[1:0];
         default:        w_ld_fault = 1'b1;
      endcase
   end

   always_comb begin
      w_op_result = '0;
      case (i_wb_sel)
         2'b00:   w_op_result = i_alu_result;
         2'b10:   w_op_result = i_pc + DATA_WIDTH'(4);
         2'b11:   w_op_result = i_imm;
         default: w_op_result = '0;
      endcase
   end

   // Lane select uses the offset captured at accept; the halfword at offset 1
   // is never consumed because that case faults.
   always_comb begin
      w_byte = i_mem_rdata[7:0];
      w_half = i_mem_rdata[15:0];
      case (r_off)
         2'd0: begin w_byte = i_mem_rdata[7:0];   w_half = i_mem_rdata[15:0]; end
         2'd1: begin w_byte = i_mem_rdata[15:8];  w_half = i_mem_rdata[23:8]; end
         2'd2: begin w_byte = i_mem_rdata[23:16]; w_half = i_mem_rdata[31:16]; end
         default: begin w_byte = i_mem_rdata[31:24]; w_half = i_mem_rdata[31:16]; end
      endcase
   end

   always_comb begin
      w_ld_data = i_mem_rdata;
      case (r_funct3)
         3'b000:  w_ld_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         3'b001:  w_ld_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         3'b100:  w_ld_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
         3'b101:  w_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
         default: w_ld_data = i_mem_rdata;
      endcase
   end

   // State register, captured transaction fields and registered outputs.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rd       <= '0;
         r_rd_en    <= 1'b0;
         r_funct3   <= '0;
         r_off      <= '0;
         r_wb_ready <= 1'b0;
         r_rf_wen   <= 1'b0;
         r_rf_addr  <= '0;
         r_rf_data  <= '0;
         r_wb_done  <= 1'b0;
         r_wb_err   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wb_ready <= w_ready_nxt;
         r_rf_wen   <= w_wen_nxt;
         r_rf_addr  <= w_addr_nxt;
         r_rf_data  <= w_data_nxt;
         r_wb_done  <= w_done_nxt;
         r_wb_err   <= w_err_nxt;
         if (w_accept) begin
            r_rd     <= i_wb_rd;
            r_rd_en  <= i_wb_rd_en;
            r_funct3 <= i_ld_funct3;
            r_off    <= i_alu_result[1:0];
            r_cnt    <= '0;
         end else if (r_state == S_WAIT_MEM && !i_mem_rvalid) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   // Next-state logic; memory data takes priority over the timeout edge.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_state_nxt = (w_is_load && !w_ld_fault) ? S_WAIT_MEM : S_RESP;
         end
         S_WAIT_MEM: begin
            if (i_mem_rvalid || r_cnt == TIMEOUT_LAST)
               w_state_nxt = S_RESP;
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output values for the cycle after this edge; nonzero only when entering RESP.
   always_comb begin
      w_ready_nxt = (w_state_nxt == S_IDLE);
      w_wen_nxt   = 1'b0;
      w_addr_nxt  = '0;
      w_data_nxt  = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_en_sel    = 1'b0;
      if (w_state_nxt == S_RESP) begin
         if (r_state == S_IDLE) begin
            // Only a faulting load goes straight from IDLE to RESP as a load.
            w_err_nxt  = w_is_load;
            w_data_nxt = w_is_load ? '0 : w_op_result;
            w_addr_nxt = i_wb_rd;
            w_en_sel   = i_wb_rd_en;
         end else begin
            w_err_nxt  = !i_mem_rvalid;
            w_data_nxt = i_mem_rvalid ? w_ld_data : '0;
            w_addr_nxt = r_rd;
            w_en_sel   = r_rd_en;
         end
         w_done_nxt = !w_err_nxt;
         w_wen_nxt  = w_en_sel && (|w_addr_nxt) && !w_err_nxt;
      end
   end

   assign o_wb_ready  = r_wb_ready;
   assign o_rf_wen    = r_rf_wen;
   assign o_rf_addr_d = r_rf_addr;
   assign o_rf_data_d = r_rf_data;
   assign o_wb_done   = r_wb_done;
   assign o_wb_err    = r_wb_err;

endmodule

// File: tb/tb_riscv_writeback.sv
// tb/tb_riscv_writeback.sv - self-checking bench for riscv_writeback
module tb_riscv_writeback;

   localparam int TMO = 15;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_wb_valid;
   logic        o_wb_ready;
   logic [1:0]  i_wb_sel;
   logic [4:0]  i_wb_rd;
   logic        i_wb_rd_en;
   logic [31:0] i_alu_result;
   logic [31:0] i_pc;
   logic [31:0] i_imm;
   logic [2:0]  i_ld_funct3;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_rf_wen;
   logic [4:0]  o_rf_addr_d;
   logic [31:0] o_rf_data_d;
   logic        o_wb_done;
   logic        o_wb_err;

   int n_assert = 0;
   int n_fail   = 0;

   riscv_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MEM_TIMEOUT(TMO)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_wb_valid   (i_wb_valid),
      .o_wb_ready   (o_wb_ready),
      .i_wb_sel     (i_wb_sel),
      .i_wb_rd      (i_wb_rd),
      .i_wb_rd_en   (i_wb_rd_en),
      .i_alu_result (i_alu_result),
      .i_pc         (i_pc),
      .i_imm        (i_imm),
      .i_ld_funct3  (i_ld_funct3),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata),
      .o_rf_wen     (o_rf_wen),
      .o_rf_addr_d  (o_rf_addr_d),
      .o_rf_data_d  (o_rf_data_d),
      .o_wb_done    (o_wb_done),
      .o_wb_err     (o_wb_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: edge index (after accept) of the response, error flag and data.
   function automatic void model(input logic [1:0] sel, input logic [31:0] alu,
                                 input logic [31:0] pcv, input logic [31:0] immv,
                                 input logic [2:0] f3, input logic [31:0] rdata,
                                 input int rv_edge, output int e_edge,
                                 output bit e_err, output logic [31:0] e_data);
      int     off;
      longint b;
      longint h;
      off = int'(alu % 32'd4);
      b = longint'((rdata >> (8 * off)) & 32'hFF);
      h = longint'((rdata >> (8 * off)) & 32'hFFFF);
      e_edge = 0;
      e_err  = 1'b0;
      e_data = 32'd0;
      if (sel == 2'd0) e_data = alu;
      else if (sel == 2'd2) e_data = 32'(longint'(pcv) + 4);
      else if (sel == 2'd3) e_data = immv;
      else if (f3 == 3 || f3 >= 6 || ((f3 == 1 || f3 == 5) && off % 2 == 1) ||
               (f3 == 2 && off != 0)) e_err = 1'b1;
      else if (rv_edge < 1 || rv_edge > TMO) begin
         e_edge = TMO;
         e_err  = 1'b1;
      end else begin
         e_edge = rv_edge;
         case (f3)
            3'd0:    e_data = 32'((b >= 128) ? b - 256 : b);
            3'd1:    e_data = 32'((h >= 32768) ? h - 65536 : h);
            3'd4:    e_data = 32'(b);
            3'd5:    e_data = 32'(h);
            default: e_data = rdata;
         endcase
      end
   endfunction

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!o_wb_ready && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      chk({tag, " ready"}, 32'(o_wb_ready), 32'd1);
   endtask

   // rv_edge: edge after accept at which mem_rvalid is presented (0 = never).
   task automatic run_txn(input string tag, input logic [1:0] sel, input logic [4:0] rd,
                          input logic rd_en, input logic [31:0] alu, input logic [31:0] pcv,
                          input logic [31:0] immv, input logic [2:0] f3,
                          input logic [31:0] rdata, input int rv_edge);
      int          e_edge;
      bit          e_err;
      logic [31:0] e_data;
      int          got;
      bit          e_wen;
      model(sel, alu, pcv, immv, f3, rdata, rv_edge, e_edge, e_err, e_data);
      e_wen = rd_en && (rd != 5'd0) && !e_err;
      wait_ready(tag);
      i_wb_valid   = 1'b1;
      i_wb_sel     = sel;
      i_wb_rd      = rd;
      i_wb_rd_en   = rd_en;
      i_alu_result = alu;
      i_pc         = pcv;
      i_imm        = immv;
      i_ld_funct3  = f3;
      @(negedge i_clk);
      i_wb_valid   = 1'b0;
      i_wb_sel     = 2'($urandom);
      i_alu_result = $urandom;
      i_pc         = $urandom;
      i_imm        = $urandom;
      got = -1;
      for (int k = 0; k <= 40 && got < 0; k++) begin
         if (o_wb_done || o_wb_err) got = k;
         else begin
            chk({tag, " quiet wen"}, 32'(o_rf_wen), 32'd0);
            i_mem_rvalid = (rv_edge == k + 1);
            i_mem_rdata  = (rv_edge == k + 1) ? rdata : $urandom;
            @(negedge i_clk);
         end
      end
      i_mem_rvalid = 1'b0;
      chk({tag, " edge"}, 32'(got), 32'(e_edge));
      if (got >= 0) begin
         chk({tag, " err"}, 32'(o_wb_err), 32'(e_err));
         chk({tag, " done"}, 32'(o_wb_done), 32'(!e_err));
         chk({tag, " wen"}, 32'(o_rf_wen), 32'(e_wen));
         chk({tag, " ready_lo"}, 32'(o_wb_ready), 32'd0);
         if (e_wen) chk({tag, " addr"}, 32'(o_rf_addr_d), 32'(rd));
         if (!e_err) chk({tag, " data"}, o_rf_data_d, e_data);
         @(negedge i_clk);
         chk({tag, " after pulses"}, {29'd0, o_rf_wen, o_wb_done, o_wb_err}, 32'd0);
         chk({tag, " after data"}, o_rf_data_d, 32'd0);
         chk({tag, " after ready"}, 32'(o_wb_ready), 32'd1);
      end
   endtask

   initial begin
      logic [31:0] md;
      logic [31:0] ldalu [5];
      logic [2:0]  ldf3 [5];
      int          dly [3];
      md = 32'h80FF7F01;
      ldalu = '{32'h0000_1003, 32'h0000_2003, 32'h0000_3002, 32'h0000_4000, 32'h0000_5000};
      ldf3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      dly   = '{0, 1, 7};

      i_reset = 1'b0; i_wb_valid = 1'b0; i_wb_sel = 2'd0; i_wb_rd = 5'd0; i_wb_rd_en = 1'b0;
      i_alu_result = 32'd0; i_pc = 32'd0; i_imm = 32'd0; i_ld_funct3 = 3'd0;
      i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;

      repeat (3) @(negedge i_clk);
      chk("reset outs", {27'd0, o_rf_wen, o_wb_done, o_wb_err, o_wb_ready, 1'b0}, 32'd0);
      chk("reset data", o_rf_data_d, 32'd0);
      chk("reset addr", 32'(o_rf_addr_d), 32'd0);
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("ready after reset", 32'(o_wb_ready), 32'd1);

      run_txn("alu", 2'b00, 5'd5, 1'b1, 32'h12345678, 32'h0, 32'h0, 3'd0, 32'h0, 1);
      run_txn("pc4 wrap", 2'b10, 5'd9, 1'b1, 32'h0, 32'hFFFFFFFC, 32'h0, 3'd0, 32'h0, 1);
      run_txn("imm rd0", 2'b11, 5'd0, 1'b1, 32'h0, 32'h0, 32'hABCD0000, 3'd0, 32'h0, 1);
      run_txn("imm noen", 2'b11, 5'd7, 1'b0, 32'h0, 32'h0, 32'hABCD0000, 3'd0, 32'h0, 1);

      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 3; j++)
            run_txn($sformatf("load f3=%0d d=%0d", ldf3[i], dly[j]), 2'b01, 5'd12, 1'b1,
                    ldalu[i], 32'h0, 32'h0, ldf3[i], md, dly[j] + 1);

      run_txn("mis lh", 2'b01, 5'd3, 1'b1, 32'h101, 32'h0, 32'h0, 3'b001, md, 1);
      run_txn("mis lw", 2'b01, 5'd3, 1'b1, 32'h102, 32'h0, 32'h0, 3'b010, md, 1);
      run_txn("bad f3", 2'b01, 5'd3, 1'b1, 32'h100, 32'h0, 32'h0, 3'b011, md, 1);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = md;
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      chk("stray rvalid pulses", {29'd0, o_rf_wen, o_wb_done, o_wb_err}, 32'd0);
      chk("stray rvalid ready", 32'(o_wb_ready), 32'd1);

      run_txn("timeout", 2'b01, 5'd4, 1'b1, 32'h200, 32'h0, 32'h0, 3'b010, md, 0);
      run_txn("rvalid on last edge", 2'b01, 5'd4, 1'b1, 32'h200, 32'h0, 32'h0, 3'b010, md, TMO);
      run_txn("rvalid too late", 2'b01, 5'd4, 1'b1, 32'h200, 32'h0, 32'h0, 3'b010, md, TMO + 1);

      for (int i = 0; i < 40; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         run_txn($sformatf("rand%0d", i), 2'($urandom), 5'($urandom), 1'($urandom),
                 $urandom, $urandom, $urandom, 3'($urandom), $urandom,
                 (i % 13 == 5) ? TMO : r);
      end

      // Reset in the middle of WAIT_MEM drops the load.
      wait_ready("rst mid");
      i_wb_valid = 1'b1; i_wb_sel = 2'b01; i_wb_rd = 5'd6; i_wb_rd_en = 1'b1;
      i_alu_result = 32'h0; i_ld_funct3 = 3'b010;
      @(negedge i_clk);
      i_wb_valid = 1'b0;
      @(negedge i_clk);
      i_reset = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata = md;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         chk($sformatf("rst mid outs %0d", k),
             {28'd0, o_rf_wen, o_wb_done, o_wb_err, o_wb_ready}, 32'd0);
         chk($sformatf("rst mid data %0d", k), o_rf_data_d, 32'd0);
      end
      i_reset = 1'b1;
      i_mem_rvalid = 1'b0;
      @(negedge i_clk);
      chk("rst mid ready", 32'(o_wb_ready), 32'd1);
      chk("rst mid no pulse", {29'd0, o_rf_wen, o_wb_done, o_wb_err}, 32'd0);
      run_txn("after reset alu", 2'b00, 5'd31, 1'b1, 32'hCAFEF00D, 32'h0, 32'h0, 3'd0, 32'h0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_writeback.md
# riscv_writeback

Write-back sequencer for the RISC-V non-pipelined core: the initiator on the register-file write port. It accepts one retiring instruction per handshake and selects the result source (ALU, load data, PC+4, immediate). For loads it waits for the data-memory response and extracts, sign- or zero-extends the byte lane. It then drives one single-cycle write (`rf_wen`, `rf_addr_d`, `rf_data_d`) into the register file.

## Interface
- `DATA_WIDTH`, 32, datapath width; only 32 is supported.
- `ADDR_WIDTH`, 5, register address width.
- `MEM_TIMEOUT`, 15, cycles spent in WAIT_MEM without `mem_rvalid` before the load is aborted; range 1..255.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `wb_valid`  in  1  retiring-instruction request.
- `wb_ready`  out  1  block can accept; registered.
- `wb_sel`  in  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM.
- `wb_rd`  in  ADDR_WIDTH  destination register.
- `wb_rd_en`  in  1  instruction writes `rd`.
- `alu_result`  in  32  ALU result; for loads, the byte address (bits [1:0] = lane offset).
- `pc`  in  32  instruction PC.
- `imm`  in  32  decoded immediate.
- `ld_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  32  aligned memory word.
- `rf_wen`  out  1  register-file write enable; one-cycle pulse.
- `rf_addr_d`  out  ADDR_WIDTH  write address.
- `rf_data_d`  out  32  write data.
- `wb_done`  out  1  one-cycle completion pulse.
- `wb_err`  out  1  one-cycle error pulse (misaligned, illegal `funct3`, or timeout).

## Operation
- States: IDLE, WAIT_MEM, RESP. `reset` = 0 at an edge forces IDLE from any state.
  - Reset also clears the timeout counter and all outputs, including `wb_ready`.
  - A transaction in flight when reset asserts is dropped: no write and no pulse.
- `wb_ready` = 1 only in IDLE. It is set at the first edge with `reset` = 1.
- Accept occurs when `wb_valid` and `wb_ready` are both 1 at a rising edge. At accept, the block captures `wb_sel`, `wb_rd`, `wb_rd_en`, operands, `ld_funct3` and `alu_result[1:0]`, and clears `wb_ready`.
- IDLE -> RESP on accept of a non-load, with result computed as:
  - ALU: `alu_result`
  - PC+4: `pc` + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000)
  - IMM: `imm`
- IDLE -> WAIT_MEM on accept of a load that is aligned and has a legal `funct3`.
- IDLE -> RESP with the error flag set on accept of a load with a fault. Such loads never wait for memory. Fault conditions:
  - LH/LHU with offset[0] = 1
  - LW with offset != 0
  - `funct3` in {011, 110, 111}
- WAIT_MEM, on `mem_rvalid` = 1:
  - Data select by load type:
    - LB/LBU: `mem_rdata` byte at `offset*8`
    - LH/LHU: halfword at `offset*8`
    - LW: the whole word
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - -> RESP.
- WAIT_MEM timeout: the counter increments each edge without `mem_rvalid`. When it reaches `MEM_TIMEOUT`, the block goes -> RESP with the error flag set. If `mem_rvalid` arrives on that same edge, the data wins.
- `mem_rvalid` outside WAIT_MEM is ignored.
- RESP lasts exactly one cycle:
  - `wb_done` = 1, or `wb_err` = 1 instead on error; never both.
  - `rf_wen` = `wb_rd_en` AND (`rd` != 0) AND no error.
  - `rf_addr_d` / `rf_data_d` hold the captured rd and the result.
  - RESP -> IDLE, with `wb_ready` set on that edge.
- Outside RESP: `rf_wen`, `wb_done` and `wb_err` are 0; `rf_addr_d` / `rf_data_d` are 0.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Non-load or faulting load accepted at edge E0:
  - RESP outputs are valid in cycle E0..E1.
  - `wb_ready` = 1 after E1.
  - Next possible accept is at E2.
  - Throughput: 1 instruction per 2 cycles.
- Load accepted at E0, `mem_rvalid` sampled at Ek (k ≥ 1):
  - RESP outputs are valid during Ek..Ek+1.
  - Next accept at Ek+2 or later.
- Timeout: `wb_err` is pulsed in the cycle after edge E0+`MEM_TIMEOUT`.
- The register file samples `rf_wen`, `rf_addr_d` and `rf_data_d` during the RESP cycle. Address and data are stable for the whole cycle.

## Test plan
- Reset held for 3 cycles mid-WAIT_MEM -> all outputs 0 and no `rf_wen` pulse. `wb_ready` = 1 one edge after release.
- ALU write: `wb_sel` = 00, rd = 5, `alu_result` = 0x12345678 -> one-cycle `rf_wen` with addr 5, data 0x12345678, and `wb_done` one cycle after accept. `wb_sel` = 10 with `pc` = 0xFFFFFFFC -> data 0x00000000.
- rd = 0, or `wb_rd_en` = 0, with IMM 0xABCD0000 -> `wb_done` = 1 and `rf_wen` = 0.
- Loads with `mem_rdata` = 0x80FF7F01:
  - LB offset 3 -> 0xFFFFFF80
  - LBU offset 3 -> 0x00000080
  - LH offset 2 -> 0xFFFF80FF
  - LHU offset 0 -> 0x00007F01
  - LW -> 0x80FF7F01
  - Each with `mem_rvalid` delayed by 0, 1 and 7 cycles.
- Misaligned LH at offset 1, LW at offset 2, and `funct3` = 011 -> `wb_err` pulse one cycle after accept, `rf_wen` = 0. A stray `mem_rvalid` after the pulse is ignored.
- Timeout: load with no `mem_rvalid` -> `wb_err` pulse after `MEM_TIMEOUT` cycles and no write. Repeat with `mem_rvalid` on exactly the `MEM_TIMEOUT`-th edge -> data is written and `wb_done` = 1.
